// File: rtl/score_life_keeper.sv
// Game-state bookkeeping for the SCOREGAME phase: accumulates a packed-BCD score
// one digit per cycle, applies life loss/bonus, and times the post-loss respawn pause.
module score_life_keeper #(
  parameter int INIT_LIVES = 3,
  parameter int MAX_LIVES = 9,
  parameter int SCORE_DIGITS = 4,
  parameter logic [4*SCORE_DIGITS-1:0] POINTS_BCD = 16'h0010,
  parameter int RESPAWN_CYCLES = 50000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      newGame_i,
  input  logic                      scoreEnable_i,
  input  logic [2:0]                hitCount_i,
  input  logic                      ballLost_i,
  input  logic                      levelClear_i,
  output logic                      scoreEnd_o,
  output logic [3:0]                lives_o,
  output logic [4*SCORE_DIGITS-1:0] score_bcd_o,
  output logic                      scoreOverflow_o,
  output logic                      gameRun_internal_o
);

  localparam int SW = 4 * SCORE_DIGITS;
  localparam int DW = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
  localparam int RW = $clog2(RESPAWN_CYCLES + 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(SCORE_DIGITS - 1);
  localparam logic [SW-1:0] ALL_NINES = {SCORE_DIGITS{4'h9}};
  localparam logic [RW-1:0] RESPAWN_LOAD = RW'(RESPAWN_CYCLES);
  localparam logic [3:0] INIT_L = 4'(INIT_LIVES);
  localparam logic [3:0] MAX_L = 4'(MAX_LIVES);

  typedef enum logic [2:0] {IDLE, LATCH, ADD, LIFE, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] score_q, score_d;
  logic [3:0]    lives_q, lives_d;
  logic          overflow_q, overflow_d;
  logic [RW-1:0] respawn_q, respawn_d;
  logic [2:0]    hitsLeft_q, hitsLeft_d;
  logic [DW-1:0] digit_q, digit_d;
  logic          carry_q, carry_d;
  logic          ballLost_q, ballLost_d;
  logic          levelClear_q, levelClear_d;
  logic          scoreEnd_q, scoreEnd_d;

  int            digitBase;
  logic [4:0]    digitSum;
  logic          digitCarry;
  logic [3:0]    digitVal;
  logic [3:0]    livesTmp;

  always_ff @(posedge clk) begin
    if (reset || newGame_i) begin
      state_q      <= IDLE;
      score_q      <= '0;
      lives_q      <= INIT_L;
      overflow_q   <= 1'b0;
      respawn_q    <= '0;
      hitsLeft_q   <= '0;
      digit_q      <= '0;
      carry_q      <= 1'b0;
      ballLost_q   <= 1'b0;
      levelClear_q <= 1'b0;
      scoreEnd_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      overflow_q   <= overflow_d;
      respawn_q    <= respawn_d;
      hitsLeft_q   <= hitsLeft_d;
      digit_q      <= digit_d;
      carry_q      <= carry_d;
      ballLost_q   <= ballLost_d;
      levelClear_q <= levelClear_d;
      scoreEnd_q   <= scoreEnd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    lives_d      = lives_q;
    overflow_d   = overflow_q;
    hitsLeft_d   = hitsLeft_q;
    digit_d      = digit_q;
    carry_d      = carry_q;
    ballLost_d   = ballLost_q;
    levelClear_d = levelClear_q;
    respawn_d    = (respawn_q != '0) ? respawn_q - 1'b1 : respawn_q;
    livesTmp     = lives_q;
    digitBase    = 4 * int'(digit_q);
    digitSum     = {1'b0, score_q[digitBase +: 4]} + {1'b0, POINTS_BCD[digitBase +: 4]}
                   + {4'b0000, carry_q};
    digitCarry   = (digitSum > 5'd9);
    digitVal     = digitCarry ? 4'(digitSum - 5'd10) : digitSum[3:0];

    case (state_q)
      IDLE: begin
        if (scoreEnable_i && (respawn_q == '0)) state_d = LATCH;
      end
      LATCH: begin
        hitsLeft_d   = hitCount_i;
        ballLost_d   = ballLost_i;
        levelClear_d = levelClear_i;
        digit_d      = '0;
        carry_d      = 1'b0;
        state_d      = (hitCount_i != 3'd0) ? ADD : LIFE;
      end
      ADD: begin
        // A saturated score is frozen at all 9s; the digit walk still runs out its bricks.
        if (!overflow_q) score_d[digitBase +: 4] = digitVal;
        if (digit_q == LAST_DIGIT) begin
          if (digitCarry && !overflow_q) begin
            score_d    = ALL_NINES;
            overflow_d = 1'b1;
            state_d    = LIFE;
          end else begin
            hitsLeft_d = hitsLeft_q - 3'd1;
            digit_d    = '0;
            carry_d    = 1'b0;
            if (hitsLeft_q == 3'd1) state_d = LIFE;
          end
        end else begin
          digit_d = digit_q + 1'b1;
          carry_d = digitCarry;
        end
      end
      LIFE: begin
        if (ballLost_q && (livesTmp != 4'd0)) livesTmp = livesTmp - 4'd1;
        if (levelClear_q && (livesTmp < MAX_L)) livesTmp = livesTmp + 4'd1;
        lives_d = livesTmp;
        if (ballLost_q && (livesTmp != 4'd0)) respawn_d = RESPAWN_LOAD;
        state_d = DONE;
      end
      DONE: begin
        if (!scoreEnable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    scoreEnd_d = (state_d == DONE);
  end

  always_comb begin
    scoreEnd_o         = scoreEnd_q;
    lives_o            = lives_q;
    score_bcd_o        = score_q;
    scoreOverflow_o    = overflow_q;
    gameRun_internal_o = (respawn_q == '0);
  end

endmodule

// File: tb/tb_score_life_keeper.sv
// Self-checking bench: two instances (10 and 995 points per brick) share stimulus and are
// compared against an integer-arithmetic game model, plus a directed vector table.
module tb_score_life_keeper;

  localparam int RESPAWN = 8;
  localparam int PTS0 = 10;
  localparam int PTS1 = 995;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        newGame = 1'b0;
  logic        scoreEnable = 1'b0;
  logic [2:0]  hitCount = 3'd0;
  logic        ballLost = 1'b0;
  logic        levelClear = 1'b0;

  logic        scoreEndA, scoreEndB;
  logic [3:0]  livesA, livesB;
  logic [15:0] scoreA, scoreB;
  logic        ovfA, ovfB;
  logic        runA, runB;

  int total = 0;
  int bad = 0;

  int mScore[2];
  bit mOvf[2];
  int mLives;

  typedef struct {
    int hits;
    bit lost;
    bit clear;
    bit pulse;
    int expScore;
    int expLives;
  } vec_t;

  vec_t vecs[17];

  always #5 clk = ~clk;

  score_life_keeper #(
    .INIT_LIVES(3), .MAX_LIVES(9), .SCORE_DIGITS(4),
    .POINTS_BCD(16'h0010), .RESPAWN_CYCLES(RESPAWN)
  ) dutA (
    .clk(clk), .reset(reset), .newGame_i(newGame), .scoreEnable_i(scoreEnable),
    .hitCount_i(hitCount), .ballLost_i(ballLost), .levelClear_i(levelClear),
    .scoreEnd_o(scoreEndA), .lives_o(livesA), .score_bcd_o(scoreA),
    .scoreOverflow_o(ovfA), .gameRun_internal_o(runA)
  );

  score_life_keeper #(
    .INIT_LIVES(3), .MAX_LIVES(9), .SCORE_DIGITS(4),
    .POINTS_BCD(16'h0995), .RESPAWN_CYCLES(RESPAWN)
  ) dutB (
    .clk(clk), .reset(reset), .newGame_i(newGame), .scoreEnable_i(scoreEnable),
    .hitCount_i(hitCount), .ballLost_i(ballLost), .levelClear_i(levelClear),
    .scoreEnd_o(scoreEndB), .lives_o(livesB), .score_bcd_o(scoreB),
    .scoreOverflow_o(ovfB), .gameRun_internal_o(runB)
  );

  function automatic int toBcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Whole-brick decimal arithmetic; saturation cuts the frame short at the offending brick.
  task automatic modelScore(input int idx, input int pts, input int hits, output int lat);
    lat = 3 + 4 * hits;
    if (!mOvf[idx]) begin
      for (int k = 1; k <= hits; k++) begin
        mScore[idx] += pts;
        if (mScore[idx] > 9999) begin
          mScore[idx] = 9999;
          mOvf[idx] = 1'b1;
          lat = 3 + 4 * k;
          break;
        end
      end
    end
  endtask

  task automatic modelReset();
    mScore[0] = 0;
    mScore[1] = 0;
    mOvf[0] = 1'b0;
    mOvf[1] = 1'b0;
    mLives = 3;
  endtask

  task automatic applyStimulus(input int hits, input bit lost, input bit clear, input bit pulse);
    int latA, latB, c, riseA, riseB, highA, highB, lowA, lowB, last;
    bit resp, lowAtRiseA, lowAtRiseB;
    modelScore(0, PTS0, hits, latA);
    modelScore(1, PTS1, hits, latB);
    if (lost && mLives > 0) mLives--;
    if (clear && mLives < 9) mLives++;
    resp = lost && (mLives > 0);

    checkOutput("run before frame", int'({runA, runB}), 3);
    hitCount = 3'(hits);
    ballLost = lost;
    levelClear = clear;
    scoreEnable = 1'b1;
    c = 0; riseA = -1; riseB = -1; highA = 0; highB = 0; lowA = 0; lowB = 0;
    lowAtRiseA = 1'b0; lowAtRiseB = 1'b0;
    while (c < 120) begin
      @(negedge clk);
      c++;
      if (c == 1 && pulse) scoreEnable = 1'b0;
      if (c == 2) begin
        hitCount = 3'($urandom_range(7, 0));
        ballLost = 1'($urandom_range(1, 0));
        levelClear = 1'($urandom_range(1, 0));
      end
      if (scoreEndA) begin
        if (riseA < 0) begin riseA = c; lowAtRiseA = !runA; end
        highA++;
      end
      if (scoreEndB) begin
        if (riseB < 0) begin riseB = c; lowAtRiseB = !runB; end
        highB++;
      end
      if (!runA) lowA++;
      if (!runB) lowB++;
      last = (riseA > riseB) ? riseA : riseB;
      if (riseA >= 0 && riseB >= 0 && c >= last + 10) break;
    end

    checkOutput("latency A", riseA, latA);
    checkOutput("latency B", riseB, latB);
    checkOutput("score A", int'(scoreA), toBcd(mScore[0]));
    checkOutput("score B", int'(scoreB), toBcd(mScore[1]));
    checkOutput("overflow A", int'(ovfA), int'(mOvf[0]));
    checkOutput("overflow B", int'(ovfB), int'(mOvf[1]));
    checkOutput("lives A", int'(livesA), mLives);
    checkOutput("lives B", int'(livesB), mLives);
    checkOutput("respawn low cycles A", lowA, resp ? RESPAWN : 0);
    checkOutput("respawn low cycles B", lowB, resp ? RESPAWN : 0);
    checkOutput("respawn starts at done A", int'(lowAtRiseA), int'(resp));
    checkOutput("respawn starts at done B", int'(lowAtRiseB), int'(resp));
    checkOutput("done hold A", highA, pulse ? 1 : c - riseA + 1);
    checkOutput("done hold B", highB, pulse ? 1 : c - riseB + 1);

    scoreEnable = 1'b0;
    hitCount = 3'd0;
    ballLost = 1'b0;
    levelClear = 1'b0;
    @(negedge clk);
    checkOutput("done release", int'({scoreEndA, scoreEndB}), 0);
    checkOutput("score stable after release A", int'(scoreA), toBcd(mScore[0]));
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int quiet, rem;

    vecs[0]  = '{3, 1'b0, 1'b0, 1'b0, 16'h0030, 3};
    vecs[1]  = '{0, 1'b1, 1'b0, 1'b0, 16'h0030, 2};
    vecs[2]  = '{2, 1'b1, 1'b0, 1'b1, 16'h0050, 1};
    vecs[3]  = '{0, 1'b1, 1'b0, 1'b0, 16'h0050, 0};
    vecs[4]  = '{0, 1'b1, 1'b0, 1'b0, 16'h0050, 0};
    vecs[5]  = '{0, 1'b1, 1'b1, 1'b0, 16'h0050, 1};
    vecs[6]  = '{7, 1'b0, 1'b1, 1'b0, 16'h0120, 2};
    vecs[7]  = '{0, 1'b0, 1'b1, 1'b0, 16'h0120, 3};
    vecs[8]  = '{0, 1'b0, 1'b1, 1'b0, 16'h0120, 4};
    vecs[9]  = '{0, 1'b0, 1'b1, 1'b0, 16'h0120, 5};
    vecs[10] = '{0, 1'b0, 1'b1, 1'b0, 16'h0120, 6};
    vecs[11] = '{0, 1'b0, 1'b1, 1'b0, 16'h0120, 7};
    vecs[12] = '{0, 1'b0, 1'b1, 1'b0, 16'h0120, 8};
    vecs[13] = '{0, 1'b0, 1'b1, 1'b0, 16'h0120, 9};
    vecs[14] = '{2, 1'b0, 1'b1, 1'b0, 16'h0140, 9};
    vecs[15] = '{0, 1'b1, 1'b1, 1'b0, 16'h0140, 9};
    vecs[16] = '{0, 1'b1, 1'b0, 1'b0, 16'h0140, 8};

    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset score A", int'(scoreA), 0);
    checkOutput("reset score B", int'(scoreB), 0);
    checkOutput("reset lives", int'({livesA, livesB}), 8'h33);
    checkOutput("reset overflow", int'({ovfA, ovfB}), 0);
    checkOutput("reset scoreEnd", int'({scoreEndA, scoreEndB}), 0);
    checkOutput("reset gameRun", int'({runA, runB}), 3);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].hits, vecs[i].lost, vecs[i].clear, vecs[i].pulse);
      checkOutput($sformatf("table %0d score", i), int'(scoreA), vecs[i].expScore);
      checkOutput($sformatf("table %0d lives", i), int'(livesA), vecs[i].expLives);
    end

    for (int i = 0; i < 60; i++) begin
      applyStimulus($urandom_range(7, 0), ($urandom_range(3, 0) == 0),
                    ($urandom_range(3, 0) == 0), ($urandom_range(4, 0) == 0));
    end

    while (mScore[0] + 70 <= 9990) applyStimulus(7, 1'b0, 1'b0, 1'b0);
    rem = (9990 - mScore[0]) / 10;
    if (rem > 0) applyStimulus(rem, 1'b0, 1'b0, 1'b0);
    checkOutput("fill score", int'(scoreA), 16'h9990);

    applyStimulus(2, 1'b0, 1'b0, 1'b0);
    checkOutput("saturated score", int'(scoreA), 16'h9999);
    checkOutput("saturated flag", int'(ovfA), 1);
    applyStimulus(3, 1'b0, 1'b0, 1'b0);
    checkOutput("saturated score held", int'(scoreA), 16'h9999);
    checkOutput("saturated flag sticky", int'(ovfA), 1);

    // newGame arriving mid-ADD while scoreEnable is still high must abandon the frame.
    scoreEnable = 1'b1;
    hitCount = 3'd5;
    repeat (6) @(negedge clk);
    newGame = 1'b1;
    @(negedge clk);
    newGame = 1'b0;
    scoreEnable = 1'b0;
    hitCount = 3'd0;
    checkOutput("newGame score A", int'(scoreA), 0);
    checkOutput("newGame score B", int'(scoreB), 0);
    checkOutput("newGame lives", int'({livesA, livesB}), 8'h33);
    checkOutput("newGame overflow", int'({ovfA, ovfB}), 0);
    checkOutput("newGame scoreEnd", int'({scoreEndA, scoreEndB}), 0);
    checkOutput("newGame gameRun", int'({runA, runB}), 3);
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (scoreEndA || scoreEndB) quiet++;
      if (scoreA != 16'h0000 || scoreB != 16'h0000) quiet++;
    end
    checkOutput("newGame idle quiet", quiet, 0);
    modelReset();
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    checkOutput("after newGame score", int'(scoreA), 16'h0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
